// File: rtl/complex_mv_row_sequencer.sv
// complex_mv_row_sequencer
//   Feeds a complex dot-product unit one matrix row at a time for a
//   matrix-vector multiply. For each of NR rows it reads the row and the
//   vector beat by beat from two sync-read memories and presents each beat on
//   the dp rows for two cycles. The dot unit consumes one half per cycle. The
//   sequencer then waits for dp_finish, or gives up after TIMEOUT cycles, and
//   offers the result on a valid/ready port.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start / busy / done / err  job control and status (err is a sticky timeout flag)
//   mat_* / vec_*              memory read strobes, word addresses and read data
//   dp_*                       dot-unit control, row beats, finish and result
//   res_valid/ready/data/index result handshake, data and row index
module complex_mv_row_sequencer #(
    parameter  int element_width = 64,
    parameter  int NI            = 8,
    parameter  int NOE           = 8,
    parameter  int NR            = 8,
    parameter  int ADDR_W        = 16,
    parameter  int TIMEOUT       = 64,
    localparam int RW            = (NR > 1) ? $clog2(NR) : 1,
    localparam int BW            = NI * element_width
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     mat_rd_en,
    output logic [ADDR_W-1:0]        mat_addr,
    input  logic [BW-1:0]            mat_rd_data,
    output logic                     vec_rd_en,
    output logic [ADDR_W-1:0]        vec_addr,
    input  logic [BW-1:0]            vec_rd_data,
    output logic                     dp_reset,
    output logic                     dp_read_now,
    output logic [BW-1:0]            dp_first_row,
    output logic [BW-1:0]            dp_second_row,
    input  logic                     dp_finish,
    input  logic [element_width-1:0] dp_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [element_width-1:0] res_data,
    output logic [RW-1:0]            res_index
);
    localparam int W   = element_width;
    localparam int BPR = (NOE + NI - 1) / NI;
    localparam int BTW = $clog2(BPR + 1);      // beat counter runs 0..BPR
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_FETCH, S_STREAM, S_WAIT, S_EMIT, S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [BTW-1:0]     beat_q, beat_d;
    logic               phase_q, phase_d;     // 0: first cycle of a beat slot, 1: second
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               rd_en_q, rd_en_d, dp_reset_q, dp_reset_d;
    logic               read_now_q, read_now_d, res_valid_q, res_valid_d;
    logic [ADDR_W-1:0]  mat_addr_q, mat_addr_d, vec_addr_q, vec_addr_d;
    logic [BW-1:0]      first_q, first_d, second_q, second_d;
    logic [W-1:0]       res_data_q, res_data_d;
    logic [RW-1:0]      res_index_q, res_index_d;
    logic [BW-1:0]      mat_masked, vec_masked;
    logic [ADDR_W-1:0]  row_base;

    assign row_base = ADDR_W'(row_q) * ADDR_W'(BPR);

    // Zero the slices past the end of the row. Only the tail beat is affected.
    always_comb begin
        mat_masked = mat_rd_data;
        vec_masked = vec_rd_data;
        for (int j = 0; j < NI; j++) begin
            if (int'(beat_q) * NI + j >= NOE) begin
                mat_masked[(NI-j)*W-1 -: W] = '0;
                vec_masked[(NI-j)*W-1 -: W] = '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        beat_d      = beat_q;
        phase_d     = phase_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        err_d       = err_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        dp_reset_d  = 1'b0;
        read_now_d  = 1'b0;
        mat_addr_d  = mat_addr_q;
        vec_addr_d  = vec_addr_q;
        first_d     = first_q;
        second_d    = second_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        case (state_q)
            S_IDLE: if (start) begin
                err_d      = 1'b0;
                busy_d     = 1'b1;
                row_d      = '0;
                dp_reset_d = 1'b1;
                state_d    = S_CLR;
            end
            S_CLR: begin
                rd_en_d    = 1'b1;
                mat_addr_d = row_base;
                vec_addr_d = '0;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                read_now_d = 1'b1;
                beat_d     = '0;
                phase_d    = 1'b0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (!phase_q) begin
                    if (int'(beat_q) == BPR) begin
                        first_d  = '0;
                        second_d = '0;
                        tmo_d    = '0;
                        state_d  = S_WAIT;
                    end else begin
                        // Read data for this beat lands now. Latch it, and
                        // fetch the next beat while this one is held.
                        first_d  = mat_masked;
                        second_d = vec_masked;
                        phase_d  = 1'b1;
                        if (int'(beat_q) < BPR - 1) begin
                            rd_en_d    = 1'b1;
                            mat_addr_d = row_base + ADDR_W'(beat_q) + ADDR_W'(1);
                            vec_addr_d = ADDR_W'(beat_q) + ADDR_W'(1);
                        end
                    end
                end else begin
                    phase_d = 1'b0;
                    beat_d  = beat_q + BTW'(1);
                end
            end
            S_WAIT: begin
                if (dp_finish) begin
                    res_data_d  = dp_result;
                    res_index_d = row_q;
                    res_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (int'(tmo_q) == TIMEOUT - 1) begin
                    // The unit has had TIMEOUT WAIT cycles. Emit a zero
                    // result and keep the job going.
                    err_d       = 1'b1;
                    res_data_d  = '0;
                    res_index_d = row_q;
                    res_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_EMIT: if (res_ready) begin
                res_valid_d = 1'b0;
                if (int'(row_q) == NR - 1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else begin
                    row_d      = row_q + RW'(1);
                    dp_reset_d = 1'b1;
                    state_d    = S_CLR;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            beat_q      <= '0;
            phase_q     <= 1'b0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            dp_reset_q  <= 1'b1;
            read_now_q  <= 1'b0;
            mat_addr_q  <= '0;
            vec_addr_q  <= '0;
            first_q     <= '0;
            second_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_index_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            beat_q      <= beat_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            dp_reset_q  <= dp_reset_d;
            read_now_q  <= read_now_d;
            mat_addr_q  <= mat_addr_d;
            vec_addr_q  <= vec_addr_d;
            first_q     <= first_d;
            second_q    <= second_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mat_rd_en     = rd_en_q;
    assign vec_rd_en     = rd_en_q;
    assign mat_addr      = mat_addr_q;
    assign vec_addr      = vec_addr_q;
    assign dp_reset      = dp_reset_q;
    assign dp_read_now   = read_now_q;
    assign dp_first_row  = first_q;
    assign dp_second_row = second_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign res_index     = res_index_q;
endmodule

// File: tb/tb_complex_mv_row_sequencer.sv
// Bench for complex_mv_row_sequencer: NOE=12, NI=8 (two beats per row, padded
// tail), NR=3. It contains sync-read memory models, a behavioural dot unit that
// consumes half a beat per cycle, and a reference that computes each row's dot
// product directly from the memory contents.
`timescale 1ns/1ps
module tb_complex_mv_row_sequencer;
    localparam int W = 64, NI = 8, NOE = 12, NR = 3, ADDR_W = 16, TIMEOUT = 16;
    localparam int BPR = (NOE + NI - 1) / NI;
    localparam int RW  = $clog2(NR);
    localparam int BW  = NI * W;
    localparam int MA  = $clog2(NR * BPR);
    localparam int VA  = (BPR > 1) ? $clog2(BPR) : 1;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, res_ready = 1'b0;
    logic busy, done, err, mat_rd_en, vec_rd_en, dp_reset, dp_read_now, res_valid;
    logic [ADDR_W-1:0] mat_addr, vec_addr;
    logic [BW-1:0] mat_rd_data = '0, vec_rd_data = '0, dp_first_row, dp_second_row;
    logic dp_finish;
    logic [W-1:0] dp_result, res_data;
    logic [RW-1:0] res_index;

    int compared = 0, mism = 0;

    complex_mv_row_sequencer #(.element_width(W), .NI(NI), .NOE(NOE), .NR(NR),
                               .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .mat_rd_en(mat_rd_en), .mat_addr(mat_addr), .mat_rd_data(mat_rd_data),
        .vec_rd_en(vec_rd_en), .vec_addr(vec_addr), .vec_rd_data(vec_rd_data),
        .dp_reset(dp_reset), .dp_read_now(dp_read_now), .dp_first_row(dp_first_row),
        .dp_second_row(dp_second_row), .dp_finish(dp_finish), .dp_result(dp_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index));

    always #5 clk = ~clk;

    // ---------------- memories ----------------
    logic [BW-1:0] mat_mem [1<<MA];
    logic [BW-1:0] vec_mem [1<<VA];
    always @(posedge clk) begin
        if (mat_rd_en) mat_rd_data <= mat_mem[mat_addr[MA-1:0]];
        if (vec_rd_en) vec_rd_data <= vec_mem[vec_addr[VA-1:0]];
    end

    function automatic logic [W-1:0] elem(input logic [BW-1:0] word, input int j);
        return word[(NI-j)*W-1 -: W];
    endfunction

    function automatic logic [W-1:0] cmac(input logic [W-1:0] acc, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [31:0] re, im;
        re = acc[63:32] + a[63:32] * b[63:32] - a[31:0] * b[31:0];
        im = acc[31:0] + a[63:32] * b[31:0] + a[31:0] * b[63:32];
        return {re, im};
    endfunction

    // Reference: sum over the NOE real elements of row r times the vector.
    function automatic logic [W-1:0] exp_dot(input int r);
        logic [W-1:0] acc = '0;
        for (int k = 0; k < NOE; k++)
            acc = cmac(acc, elem(mat_mem[MA'(r*BPR + k/NI)], k % NI),
                       elem(vec_mem[VA'(k/NI)], k % NI));
        return acc;
    endfunction

    // ---------------- dot unit model ----------------
    bit dact = 0, fin = 0, hang = 0;
    int dcnt = 0, dwait = 0, dot_lat = 0;
    logic [W-1:0] acc = '0;
    logic [BW-1:0] tail_first = '0, tail_second = '0;

    function automatic logic [W-1:0] dot_half(input logic [W-1:0] a0, input logic [BW-1:0] f,
                                              input logic [BW-1:0] s, input int h);
        logic [W-1:0] a = a0;
        for (int j = h*NI/2; j < (h+1)*NI/2; j++) a = cmac(a, elem(f, j), elem(s, j));
        return a;
    endfunction

    always @(posedge clk) begin
        if (dp_reset) begin
            dact <= 0; fin <= 0; acc <= '0; dwait <= 0;
        end else if (dp_read_now) begin
            dact <= 1; dcnt <= 0; acc <= '0;
        end else if (dact) begin
            acc <= dot_half(acc, dp_first_row, dp_second_row, dcnt % 2);
            if (dcnt == 2*BPR - 2) begin tail_first <= dp_first_row; tail_second <= dp_second_row; end
            dcnt <= dcnt + 1;
            if (dcnt == 2*BPR - 1) begin
                dact <= 0;
                if (dot_lat == 0) fin <= !hang; else dwait <= dot_lat;
            end
        end else if (dwait > 0) begin
            dwait <= dwait - 1;
            if (dwait == 1) fin <= !hang;
        end
    end
    assign dp_finish = fin;
    assign dp_result = acc;

    // ---------------- monitor (logs only) ----------------
    int addr_log[$], vaddr_log[$];
    int done_cnt = 0, en_bad = 0;
    always @(posedge clk) begin
        if (mat_rd_en) begin addr_log.push_back(int'(mat_addr)); vaddr_log.push_back(int'(vec_addr)); end
        if (mat_rd_en !== vec_rd_en) en_bad++;
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- helpers (no checking) ----------------
    task automatic tick; @(posedge clk); #1; endtask

    task automatic pulse_start; start = 1'b1; tick; start = 1'b0; endtask

    task automatic fill_mem(input bit ones);
        for (int a = 0; a < (1<<MA); a++)
            for (int j = 0; j < NI; j++) mat_mem[a][(NI-j)*W-1 -: W] = {$urandom, $urandom};
        for (int a = 0; a < (1<<VA); a++)
            for (int j = 0; j < NI; j++) vec_mem[a][(NI-j)*W-1 -: W] = {$urandom, $urandom};
        if (ones) begin
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < NOE; k++)
                    mat_mem[MA'(r*BPR + k/NI)][(NI-k%NI)*W-1 -: W] = {32'd1, 32'd0};
            for (int k = 0; k < NOE; k++) vec_mem[VA'(k/NI)][(NI-k%NI)*W-1 -: W] = {32'd1, 32'd0};
        end
    endtask

    // Waits (bounded) for a result, holds ready low for `hold` cycles, then accepts it.
    // Ready toggles randomly while valid is low.
    task automatic get_result(input int hold, output bit ok, output logic [W-1:0] d,
                              output logic [RW-1:0] idx, output logic e);
        int n = 0;
        ok = 0; d = '0; idx = '0; e = 1'b0;
        while (res_valid !== 1'b1 && n < 300) begin res_ready = 1'($urandom_range(0, 1)); tick; n++; end
        res_ready = 1'b0;
        if (res_valid === 1'b1) begin
            ok = 1; d = res_data; idx = res_index; e = err;
            for (int i = 0; i < hold; i++) tick;
            res_ready = 1'b1; tick; res_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        compared++;
        if ({busy, done, err, res_valid, mat_rd_en, vec_rd_en, dp_read_now, dp_reset} !== 8'b0000_0001) begin
            mism++; $display("FAIL reset_ctrl: got %b want 00000001",
                {busy, done, err, res_valid, mat_rd_en, vec_rd_en, dp_read_now, dp_reset});
        end
        compared++;
        if (dp_first_row !== '0 || dp_second_row !== '0 || mat_addr !== '0 || vec_addr !== '0) begin
            mism++; $display("FAIL reset_data: rows/addrs not zero, addr=%0d vaddr=%0d", mat_addr, vec_addr);
        end
        compared++;
        if (res_data !== '0 || res_index !== '0) begin
            mism++; $display("FAIL reset_res: got data=%h idx=%0d want 0/0", res_data, res_index);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_ones;
        bit ok; logic [W-1:0] d; logic [RW-1:0] idx; logic e;
        int a0 = addr_log.size(), d0 = done_cnt, bad = 0;
        fill_mem(1); dot_lat = 0; hang = 0;
        pulse_start;
        compared++;
        if ({busy, dp_reset, mat_rd_en, dp_read_now} !== 4'b1100) begin
            mism++; $display("FAIL ones_clr: got %b want 1100", {busy, dp_reset, mat_rd_en, dp_read_now});
        end
        tick;
        compared++;
        if ({busy, dp_reset, mat_rd_en, dp_read_now} !== 4'b1010 || mat_addr !== '0) begin
            mism++; $display("FAIL ones_fetch: got %b addr=%0d want 1010 addr=0",
                {busy, dp_reset, mat_rd_en, dp_read_now}, mat_addr);
        end
        tick;
        compared++;
        if ({busy, dp_reset, mat_rd_en, dp_read_now} !== 4'b1001) begin
            mism++; $display("FAIL ones_stream: got %b want 1001", {busy, dp_reset, mat_rd_en, dp_read_now});
        end
        for (int r = 0; r < NR; r++) begin
            get_result(0, ok, d, idx, e);
            compared++;
            if (!ok || idx !== RW'(r) || d !== 64'h0000000C_00000000) begin
                mism++; $display("FAIL ones_row%0d: got ok=%0d idx=%0d data=%h want idx=%0d data=0000000c00000000",
                    r, ok, idx, d, r);
            end
        end
        compared++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            mism++; $display("FAIL ones_done: got done=%b busy=%b want 1/0", done, busy);
        end
        tick;
        for (int j = 0; j < NI; j++) begin
            logic [W-1:0] want = (BPR*NI - NI + j < NOE) ? {32'd1, 32'd0} : '0;
            if (elem(tail_first, j) !== want || elem(tail_second, j) !== want) bad++;
        end
        compared++;
        if (bad != 0) begin mism++; $display("FAIL ones_tail_pad: got %0d bad slices want 0", bad); end
        bad = 0;
        if (addr_log.size() - a0 != NR*BPR) bad++;
        else for (int i = 0; i < NR*BPR; i++) if (addr_log[a0+i] != i || vaddr_log[a0+i] != i % BPR) bad++;
        compared++;
        if (bad != 0 || en_bad != 0) begin
            mism++; $display("FAIL ones_addrs: got %0d bad addrs, %0d strobe splits want 0/0", bad, en_bad);
        end
        compared++;
        if (done_cnt - d0 != 1) begin mism++; $display("FAIL ones_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_random;
        bit ok; logic [W-1:0] d; logic [RW-1:0] idx; logic e;
        for (int job = 0; job < 4; job++) begin
            fill_mem(0); dot_lat = $urandom_range(0, 3); hang = 0;
            pulse_start;
            for (int r = 0; r < NR; r++) begin
                get_result($urandom_range(0, 3), ok, d, idx, e);
                compared++;
                if (!ok || idx !== RW'(r) || d !== exp_dot(r) || e !== 1'b0) begin
                    mism++; $display("FAIL rand_j%0d_row%0d: got ok=%0d idx=%0d data=%h err=%b want idx=%0d data=%h err=0",
                        job, r, ok, idx, d, e, r, exp_dot(r));
                end
            end
            compared++;
            if (done !== 1'b1) begin mism++; $display("FAIL rand_done_j%0d: got %b want 1", job, done); end
            tick;
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mism++; $display("FAIL rand_idle_j%0d: got done=%b busy=%b want 0/0", job, done, busy);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] d0; int n; int bad;
        fill_mem(0); dot_lat = 1; hang = 0;
        pulse_start;
        for (int r = 0; r < NR; r++) begin
            n = 0; bad = 0;
            while (res_valid !== 1'b1 && n < 300) begin tick; n++; end
            d0 = res_data;
            compared++;
            if (res_valid !== 1'b1 || d0 !== exp_dot(r)) begin
                mism++; $display("FAIL bp_data_row%0d: got valid=%b data=%h want 1/%h", r, res_valid, d0, exp_dot(r));
            end
            for (int i = 0; i < 10; i++) begin
                tick;
                if (res_valid !== 1'b1 || res_data !== d0 || dp_reset !== 1'b0) bad++;
            end
            compared++;
            if (bad != 0) begin mism++; $display("FAIL bp_hold_row%0d: got %0d unstable cycles want 0", r, bad); end
            res_ready = 1'b1; tick; res_ready = 1'b0;
            compared++;
            if (res_valid !== 1'b0 || (r < NR-1 ? dp_reset !== 1'b1 : done !== 1'b1)) begin
                mism++; $display("FAIL bp_accept_row%0d: got valid=%b dp_reset=%b done=%b", r, res_valid, dp_reset, done);
            end
        end
        tick;
    endtask

    task automatic test_timeout;
        bit ok; logic [W-1:0] d; logic [RW-1:0] idx; logic e;
        fill_mem(0); dot_lat = 0; hang = 1;
        pulse_start;
        for (int r = 0; r < NR; r++) begin
            get_result(0, ok, d, idx, e);
            compared++;
            if (!ok || e !== 1'b1 || d !== '0 || idx !== RW'(r)) begin
                mism++; $display("FAIL tmo_row%0d: got ok=%0d err=%b data=%h idx=%0d want err=1 data=0 idx=%0d",
                    r, ok, e, d, idx, r);
            end
        end
        compared++;
        if (done !== 1'b1 || err !== 1'b1) begin
            mism++; $display("FAIL tmo_done: got done=%b err=%b want 1/1", done, err);
        end
        tick;
        hang = 0;
        pulse_start;
        compared++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            mism++; $display("FAIL tmo_clear: got err=%b busy=%b want 0/1", err, busy);
        end
        for (int r = 0; r < NR; r++) begin
            get_result(0, ok, d, idx, e);
            compared++;
            if (!ok || e !== 1'b0 || d !== exp_dot(r)) begin
                mism++; $display("FAIL tmo_after_row%0d: got err=%b data=%h want 0/%h", r, e, d, exp_dot(r));
            end
        end
        tick;
    endtask

    task automatic test_reset_midjob;
        bit ok; logic [W-1:0] d; logic [RW-1:0] idx; logic e;
        int rn = 0, n = 0, d0;
        fill_mem(0); dot_lat = 0; hang = 0;
        pulse_start;
        res_ready = 1'b1;
        while (rn < 2 && n < 300) begin tick; n++; if (dp_read_now === 1'b1) rn++; end
        compared++;
        if (rn != 2) begin mism++; $display("FAIL mid_reach_row1: got %0d read_now pulses want 2", rn); end
        reset = 1'b1; tick;
        compared++;
        if ({busy, done, err, res_valid, mat_rd_en, vec_rd_en, dp_read_now, dp_reset} !== 8'b0000_0001 ||
            dp_first_row !== '0 || dp_second_row !== '0 || mat_addr !== '0 || vec_addr !== '0 ||
            res_data !== '0 || res_index !== '0) begin
            mism++; $display("FAIL mid_reset_vals: got ctrl=%b addr=%0d data=%h",
                {busy, done, err, res_valid, mat_rd_en, vec_rd_en, dp_read_now, dp_reset}, mat_addr, res_data);
        end
        reset = 1'b0; res_ready = 1'b0;
        d0 = done_cnt;
        repeat (40) tick;
        compared++;
        if (done_cnt != d0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            mism++; $display("FAIL mid_no_done: got done_pulses=%0d busy=%b valid=%b want 0/0/0",
                done_cnt - d0, busy, res_valid);
        end
        fill_mem(0);
        pulse_start;
        for (int r = 0; r < NR; r++) begin
            get_result(1, ok, d, idx, e);
            compared++;
            if (!ok || idx !== RW'(r) || d !== exp_dot(r)) begin
                mism++; $display("FAIL mid_fresh_row%0d: got idx=%0d data=%h want %0d/%h", r, idx, d, r, exp_dot(r));
            end
        end
        compared++;
        if (done !== 1'b1) begin mism++; $display("FAIL mid_fresh_done: got %b want 1", done); end
        tick;
    endtask

    task automatic test_back_to_back;
        bit ok; logic [W-1:0] d; logic [RW-1:0] idx; logic e;
        int a0, d0, bad = 0;
        fill_mem(0); dot_lat = 2; hang = 0;
        a0 = addr_log.size(); d0 = done_cnt;
        pulse_start;
        for (int r = 0; r < NR; r++) begin
            start = 1'b1; tick; start = 1'b0;
            get_result(0, ok, d, idx, e);
            compared++;
            if (!ok || idx !== RW'(r) || d !== exp_dot(r)) begin
                mism++; $display("FAIL b2b_row%0d: got idx=%0d data=%h want %0d/%h", r, idx, d, r, exp_dot(r));
            end
        end
        repeat (3) tick;
        if (addr_log.size() - a0 != NR*BPR) bad++;
        else for (int i = 0; i < NR*BPR; i++) if (addr_log[a0+i] != i) bad++;
        compared++;
        if (bad != 0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            mism++; $display("FAIL b2b_single_job: got bad_addrs=%0d done_pulses=%0d busy=%b want 0/1/0",
                bad, done_cnt - d0, busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_ones;
        test_random;
        test_backpressure;
        test_timeout;
        test_reset_midjob;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
